penc_42: RTL and testbench

- Registered 4-to-2 priority encoder.
- Samples a 4-bit request vector each clock and outputs the binary index of the highest-numbered asserted bit, plus a valid flag.
- Used as a small arbitration or index-extraction leaf wherever a one-cycle-latency priority index is needed.
- Parameterised so wider variants reuse the same RTL.

---
 rtl/penc_pkg.sv | 20 ++
 rtl/penc_core.sv | 45 ++++
 rtl/penc_42.sv | 79 +++++++
 tb/tb_penc_42.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/penc_pkg.sv
// -----------------------------------------------------------------------------
// penc_pkg
// Shared definitions for the penc_42 priority-encoder family.
//   PENC_DEFAULT_N : default number of request inputs
//   penc_width(n)  : index width for n requests ($clog2(n), never below 1)
//   penc_idx_t     : index vector type at the default width
// -----------------------------------------------------------------------------
package penc_pkg;

  localparam int PENC_DEFAULT_N = 4;

  function automatic int penc_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  typedef logic [penc_width(PENC_DEFAULT_N)-1:0] penc_idx_t;

endpackage

// File: rtl/penc_core.sv
// -----------------------------------------------------------------------------
// penc_core
// Purely combinational priority encoder core. Bit N-1 of y has the highest
// priority.
// Ports:
//   y     in  [N-1:0]  request vector
//   idx   out [W-1:0]  index of the highest set bit (0 when y is all-zero)
//   any   out          at least one bit of y set
//   multi out          two or more bits of y set (only when PENC_42_MULTIHOT_EN
//                      is defined)
// -----------------------------------------------------------------------------
module penc_core
  import penc_pkg::*;
#(
  parameter int N = PENC_DEFAULT_N,
  parameter int W = penc_width(N)
) (
  input  logic [N-1:0] y,
  output logic [W-1:0] idx,
  output logic         any
`ifdef PENC_42_MULTIHOT_EN
  ,
  output logic         multi
`endif
);

  // Ascending scan with overwrite: the last (highest) set bit wins, which
  // gives the same result as a descending first-match search.
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (y[i]) idx = W'(i);
    end
  end

  assign any = |y;

`ifdef PENC_42_MULTIHOT_EN
  // Clearing the lowest set bit leaves something only if two or more were set.
  logic [N-1:0] y_minus_one;
  assign y_minus_one = y - N'(1);
  assign multi       = |(y & y_minus_one);
`endif

endmodule

// File: rtl/penc_42.sv
// -----------------------------------------------------------------------------
// penc_42
// Registered N-to-log2(N) priority encoder (4-to-2 at default N). One cycle of
// latency, a new result every cycle, synchronous active-high reset that clears
// all outputs.
// Optional feature macro: PENC_42_MULTIHOT_EN adds the registered 'multi'
// output (two or more request bits set).
// Ports:
//   clk    in           rising-edge clock
//   rst    in           synchronous active-high reset
//   y      in  [N-1:0]  request vector, bit N-1 highest priority
//   a      out [W-1:0]  registered index of highest set bit of y
//   valid  out          registered "y had any bit set"; qualifies a
//   multi  out          registered "y had two or more bits set" (macro only)
// -----------------------------------------------------------------------------
module penc_42
  import penc_pkg::*;
#(
  parameter int N = PENC_DEFAULT_N,
  parameter int W = penc_width(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] y,
  output logic [W-1:0] a,
  output logic         valid
`ifdef PENC_42_MULTIHOT_EN
  ,
  output logic         multi
`endif
);

  logic [W-1:0] a_d;
  logic         vld_d;
  logic [W-1:0] a_q;
  logic         vld_q;

`ifdef PENC_42_MULTIHOT_EN
  logic multi_d;
  logic multi_q;
`endif

  penc_core #(
    .N (N),
    .W (W)
  ) u_core (
    .y   (y),
    .idx (a_d),
    .any (vld_d)
`ifdef PENC_42_MULTIHOT_EN
    ,
    .multi (multi_d)
`endif
  );

  // ---- stage 0 -> 1: output register; reset wins over any request ----
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      vld_q <= vld_d;
    end
  end

`ifdef PENC_42_MULTIHOT_EN
  always_ff @(posedge clk) begin
    if (rst) multi_q <= 1'b0;
    else     multi_q <= multi_d;
  end

  assign multi = multi_q;
`endif

  assign a     = a_q;
  assign valid = vld_q;

endmodule

// File: tb/tb_penc_42.sv
// -----------------------------------------------------------------------------
// tb_penc_42
// Self-checking bench for penc_42 at N=4: directed vector table, a couple of
// hand-written timing sequences, an exhaustive 16-value sweep and randomized
// traffic against a behavioural model. Works in both builds; 'multi' is
// checked when PENC_42_MULTIHOT_EN is defined.
// -----------------------------------------------------------------------------
module tb_penc_42;

  logic       clk;
  logic       rst;
  logic [3:0] y;
  logic [1:0] a;
  logic       valid;
`ifdef PENC_42_MULTIHOT_EN
  logic       multi;
`endif

  int n_tests;
  int n_fail;

  penc_42 #(.N(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .y     (y),
    .a     (a),
    .valid (valid)
`ifdef PENC_42_MULTIHOT_EN
    ,
    .multi (multi)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] y;
    logic [1:0] exp_a;
    logic       exp_valid;
    logic       exp_multi;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model: highest set bit index from the arithmetic magnitude.
  function automatic int ref_idx(input int v);
    if (v == 0) return 0;
    return $clog2(v + 1) - 1;
  endfunction

  function automatic logic ref_multi(input logic [3:0] v);
    return ($countones(v) >= 2);
  endfunction

  task automatic check(input string name, input logic [1:0] ea, input logic ev,
                       input logic em);
    n_tests++;
    if (a !== ea) begin
      n_fail++;
      $display("FAIL %s a: got %b expected %b (y=%b)", name, a, ea, y);
    end
    n_tests++;
    if (valid !== ev) begin
      n_fail++;
      $display("FAIL %s valid: got %b expected %b (y=%b)", name, valid, ev, y);
    end
`ifdef PENC_42_MULTIHOT_EN
    n_tests++;
    if (multi !== em) begin
      n_fail++;
      $display("FAIL %s multi: got %b expected %b (y=%b)", name, multi, em, y);
    end
`else
    if (em === 1'bx) $display("unexpected X in expected multi for %s", name);
`endif
  endtask

  // Drive inputs on the falling edge, let one rising edge sample them, then
  // look at the outputs 1 ns later.
  task automatic apply(input logic r, input logic [3:0] v);
    @(negedge clk);
    rst = r;
    y   = v;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic [3:0] v, input logic [1:0] ea,
                     input logic ev, input logic em);
    vec_t t;
    t.rst = r; t.y = v; t.exp_a = ea; t.exp_valid = ev; t.exp_multi = em;
    vecs.push_back(t);
  endtask

  initial begin
    logic [3:0] rv;
    logic       rr;
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    y   = 4'b1111;

    // Reset, single-hot sweep, priority, latency/hold, reset mid-stream.
    add(1, 4'b1111, 2'd0, 0, 0);
    add(1, 4'b1111, 2'd0, 0, 0);
    add(0, 4'b0000, 2'd0, 0, 0);
    add(0, 4'b0001, 2'd0, 1, 0);
    add(0, 4'b0010, 2'd1, 1, 0);
    add(0, 4'b0100, 2'd2, 1, 0);
    add(0, 4'b1000, 2'd3, 1, 0);
    add(0, 4'b0101, 2'd2, 1, 1);
    add(0, 4'b0011, 2'd1, 1, 1);
    add(0, 4'b1111, 2'd3, 1, 1);
    add(0, 4'b1010, 2'd3, 1, 1);
    add(0, 4'b1000, 2'd3, 1, 0);
    add(0, 4'b0000, 2'd0, 0, 0);
    add(1, 4'b0100, 2'd0, 0, 0);
    add(0, 4'b0100, 2'd2, 1, 0);
    add(0, 4'b0101, 2'd2, 1, 1);
    add(0, 4'b0100, 2'd2, 1, 0);
    add(0, 4'b0000, 2'd0, 0, 0);

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].y);
      check($sformatf("vec%0d", i), vecs[i].exp_a, vecs[i].exp_valid,
            vecs[i].exp_multi);
    end

    // Hold: a change of y mid-cycle must not reach the outputs before the edge.
    apply(0, 4'b0010);
    check("hold_pre", 2'd1, 1'b1, 1'b0);
    #2 y = 4'b1001;
    #1;
    check("hold_mid", 2'd1, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check("hold_post", 2'd3, 1'b1, 1'b1);

    // Reset asserted while a result is being held clears it on the next edge.
    apply(1, 4'b1100);
    check("rst_clear", 2'd0, 1'b0, 1'b0);
    apply(0, 4'b1100);
    check("rst_release", 2'd3, 1'b1, 1'b1);

    // Exhaustive sweep of all 16 request values.
    for (int v = 0; v < 16; v++) begin
      apply(0, 4'(v));
      check($sformatf("sweep%0d", v), 2'(ref_idx(v)), (v != 0),
            ref_multi(4'(v)));
    end

    // Randomized traffic with occasional reset.
    for (int k = 0; k < 300; k++) begin
      rv = 4'($urandom_range(0, 15));
      rr = ($urandom_range(0, 15) == 0);
      apply(rr, rv);
      if (rr) check($sformatf("rand%0d", k), 2'd0, 1'b0, 1'b0);
      else    check($sformatf("rand%0d", k), 2'(ref_idx(int'(rv))), (rv != 0),
                    ref_multi(rv));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time bound so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
